uart_tx_engine: RTL and testbench
=================================

UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 Parameter DATA_WIDTH, default 8, meaning payload bits per frame; legal range 5..9.
REQ-002 CLK  input  1  bit-rate clock; one serial bit per CLK cycle.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 P_DATA  input  DATA_WIDTH  parallel payload, sampled only on frame accept.
REQ-005 DATA_VALID  input  1  frame request, sampled on CLK rising edge.
REQ-006 PAR_EN  input  1  1 = insert parity bit, sampled on frame accept.
REQ-007 PAR_TYP  input  1  0 = even parity, 1 = odd parity, sampled on frame accept.
REQ-008 STOP2  input  1  0 = one stop bit, 1 = two stop bits, sampled on frame accept.
REQ-009 TX_OUT  output  1  registered serial line; idle level 1.
REQ-010 BUSY  output  1  registered; 1 while a frame occupies the line.

Function
REQ-011 The block SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-012 Accept: at a rising edge in IDLE with DATA_VALID=1, the block SHALL latch P_DATA, PAR_EN, PAR_TYP and STOP2, enter START, and drive TX_OUT=0 and BUSY=1 from that edge.
REQ-013 START SHALL last 1 cycle, then enter DATA.
REQ-014 DATA SHALL last exactly DATA_WIDTH cycles and shift out the latched data LSB first.
- Bit counter SHALL be ceil(log2(DATA_WIDTH)) wide.
- Counter SHALL clear on accept.
REQ-015 After the last data bit the block SHALL enter PARITY if latched PAR_EN=1, else STOP.
REQ-016 PARITY SHALL last 1 cycle and drive the XOR of the latched data bits.
- Even: XOR value.
- Odd: inverted XOR value.
REQ-017 Parity SHALL be computed from the latched copy; P_DATA changes after accept SHALL NOT affect the frame.
REQ-018 STOP SHALL drive TX_OUT=1 for 1 cycle if latched STOP2=0, or 2 cycles if STOP2=1.
REQ-019 Frame length SHALL be 1+DATA_WIDTH+PAR_EN+1+STOP2 cycles, with BUSY=1 for all of them.
REQ-020 Back-to-back: if DATA_VALID=1 at the edge ending the final stop cycle, the block SHALL accept the new frame at that edge.
- Next cycle is a start bit.
- BUSY stays 1 with no idle gap.
REQ-021 Otherwise, at the end of the final stop cycle the block SHALL return to IDLE with TX_OUT=1 and BUSY=0.
REQ-022 DATA_VALID SHALL be ignored in START, DATA, PARITY and in non-final stop cycles; there is no queuing.
REQ-023 PAR_EN, PAR_TYP and STOP2 changes during a frame SHALL NOT affect the frame in progress.
REQ-024 Illegal state encodings SHALL recover to IDLE on the next edge with TX_OUT=1 and BUSY=0.

Reset
REQ-025 While RST=1 the block SHALL force state IDLE, TX_OUT=1, BUSY=0, and clear the bit counter and data register, independent of CLK.
REQ-026 A reset asserted mid-frame SHALL abandon the frame immediately; no partial-frame resumption.
REQ-027 After RST deasserts, the first accept SHALL occur no earlier than the first rising edge with RST=0 and DATA_VALID=1.

Verification
REQ-028 DATA_WIDTH=8, P_DATA=0xA5, PAR_EN=0, STOP2=0, one-cycle DATA_VALID -> TX_OUT=0,1,0,1,0,0,1,0,1,1; BUSY=1 for exactly 10 cycles.
REQ-029 P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> parity bit 0; PAR_TYP=1 -> parity bit 1; frame is 11 cycles.
REQ-030 P_DATA=0x07, PAR_EN=1, PAR_TYP=1, STOP2=1 -> data 1,1,1,0,0,0,0,0, parity 0, two stop bits 1,1; BUSY=1 for 12 cycles.
REQ-031 DATA_VALID held high with 0x55 then 0x0F -> second start bit immediately follows the first stop bit; BUSY never drops; DATA_VALID pulses mid-frame are ignored.
REQ-032 RST pulsed during data bit 3 -> TX_OUT=1 and BUSY=0 asynchronously; a new 0x3C request after release produces a complete, correct frame.
REQ-033 DATA_WIDTH=5, P_DATA=5'h13, PAR_EN=1, PAR_TYP=0 -> TX_OUT=0,1,1,0,0,1,1,1; BUSY=1 for 8 cycles.

Source files
------------

// File: rtl/uart_tx_engine.sv
// Serial transmit engine: start bit, LSB-first payload, optional even/odd
// parity and one or two stop bits, one bit per CLK cycle.
module uart_tx_engine #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] data_q;
  logic [CW-1:0]         bit_cnt;
  logic [CW-1:0]         cnt_nxt;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  stop2_q;
  logic                  stop_last;
  logic                  stop_final;
  logic                  accept;

  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  assign cnt_nxt    = bit_cnt + CW'(1);
  assign stop_final = !stop2_q || stop_last;
  // A new frame may start from IDLE or on the edge that ends the last stop bit.
  assign accept     = DATA_VALID && ((state == IDLE) || ((state == STOP) && stop_final));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      data_q    <= '0;
      bit_cnt   <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      stop2_q   <= 1'b0;
      stop_last <= 1'b0;
      TX_OUT    <= 1'b1;
      BUSY      <= 1'b0;
    end else if (accept) begin
      state     <= START;
      data_q    <= P_DATA;
      par_en_q  <= PAR_EN;
      par_typ_q <= PAR_TYP;
      stop2_q   <= STOP2;
      bit_cnt   <= '0;
      stop_last <= 1'b0;
      TX_OUT    <= 1'b0;
      BUSY      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          TX_OUT <= 1'b1;
          BUSY   <= 1'b0;
        end
        START: begin
          state  <= DATA;
          TX_OUT <= data_q[0];
        end
        DATA: begin
          if (bit_cnt == LAST_BIT) begin
            if (par_en_q) begin
              state  <= PARITY;
              TX_OUT <= parity_bit(data_q, par_typ_q);
            end else begin
              state     <= STOP;
              stop_last <= 1'b0;
              TX_OUT    <= 1'b1;
            end
          end else begin
            bit_cnt <= cnt_nxt;
            TX_OUT  <= data_q[cnt_nxt];
          end
        end
        PARITY: begin
          state     <= STOP;
          stop_last <= 1'b0;
          TX_OUT    <= 1'b1;
        end
        STOP: begin
          if (stop_final) begin
            state  <= IDLE;
            TX_OUT <= 1'b1;
            BUSY   <= 1'b0;
          end else begin
            stop_last <= 1'b1;
            TX_OUT    <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          TX_OUT <= 1'b1;
          BUSY   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine: 8-bit and 5-bit instances, expected
// line levels pushed per frame and popped by a monitor while BUSY is high.
module tb_uart_tx_engine;

  logic       clk = 1'b0;
  logic       rst;

  logic [7:0] p_data8;
  logic       dv8, par_en8, par_typ8, stop2_8;
  logic       tx8, busy8;

  logic [4:0] p_data5;
  logic       dv5, par_en5, par_typ5, stop2_5;
  logic       tx5, busy5;

  int         total = 0;
  int         bad   = 0;
  logic       q8[$];
  logic       q5[$];

  always #5 clk = ~clk;

  uart_tx_engine #(.DATA_WIDTH(8)) dut8 (
    .CLK(clk), .RST(rst), .P_DATA(p_data8), .DATA_VALID(dv8),
    .PAR_EN(par_en8), .PAR_TYP(par_typ8), .STOP2(stop2_8),
    .TX_OUT(tx8), .BUSY(busy8)
  );

  uart_tx_engine #(.DATA_WIDTH(5)) dut5 (
    .CLK(clk), .RST(rst), .P_DATA(p_data5), .DATA_VALID(dv5),
    .PAR_EN(par_en5), .PAR_TYP(par_typ5), .STOP2(stop2_5),
    .TX_OUT(tx5), .BUSY(busy5)
  );

  task automatic push8(input string s);
    for (int i = 0; i < s.len(); i++) q8.push_back(s[i] == 8'h31);
  endtask

  task automatic push5(input string s);
    for (int i = 0; i < s.len(); i++) q5.push_back(s[i] == 8'h31);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic send8(input logic [7:0] d, input logic pe, input logic pt,
                       input logic s2, input string exp);
    @(negedge clk);
    p_data8 = d; par_en8 = pe; par_typ8 = pt; stop2_8 = s2; dv8 = 1'b1;
    push8(exp);
    @(posedge clk);
    #1;
    dv8 = 1'b0;
    p_data8 = ~d; par_en8 = ~pe; par_typ8 = ~pt; stop2_8 = ~s2;
  endtask

  task automatic wait_idle8(input bit poke);
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (poke && i == 3) begin
        dv8 = 1'b1;
        p_data8 = 8'h00;
      end
      if (poke && i == 4) dv8 = 1'b0;
      if (!busy8) done = 1'b1;
    end
    check("idle8_timeout", done, 1'b1);
    check("frame8_len_left", q8.size(), 0);
  endtask

  task automatic wait_idle5();
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!busy5) done = 1'b1;
    end
    check("idle5_timeout", done, 1'b1);
    check("frame5_len_left", q5.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    p_data8 = '0; dv8 = 1'b0; par_en8 = 1'b0; par_typ8 = 1'b0; stop2_8 = 1'b0;
    p_data5 = '0; dv5 = 1'b0; par_en5 = 1'b0; par_typ5 = 1'b0; stop2_5 = 1'b0;
    fork
      begin : monitor
        forever begin
          @(negedge clk);
          if (busy8 === 1'b1) begin
            total++;
            if (q8.size() == 0) begin
              bad++;
              $display("FAIL busy8_extra got=busy tx=%0b exp=idle", tx8);
            end else begin
              logic e8;
              e8 = q8.pop_front();
              if (tx8 !== e8) begin
                bad++;
                $display("FAIL tx8_bit got=%0b exp=%0b", tx8, e8);
              end
            end
          end else begin
            total++;
            if (tx8 !== 1'b1) begin
              bad++;
              $display("FAIL tx8_idle got=%0b exp=1 busy=%0b", tx8, busy8);
            end
          end
          if (busy5 === 1'b1) begin
            total++;
            if (q5.size() == 0) begin
              bad++;
              $display("FAIL busy5_extra got=busy tx=%0b exp=idle", tx5);
            end else begin
              logic e5;
              e5 = q5.pop_front();
              if (tx5 !== e5) begin
                bad++;
                $display("FAIL tx5_bit got=%0b exp=%0b", tx5, e5);
              end
            end
          end else begin
            total++;
            if (tx5 !== 1'b1) begin
              bad++;
              $display("FAIL tx5_idle got=%0b exp=1 busy=%0b", tx5, busy5);
            end
          end
        end
      end
      begin : driver
        int gaps;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tx8", tx8, 1'b1);
        check("rst_busy8", busy8, 1'b0);
        check("rst_tx5", tx5, 1'b1);
        check("rst_busy5", busy5, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        send8(8'hA5, 1'b0, 1'b0, 1'b0, "0101001011");
        wait_idle8(1'b0);
        send8(8'hA5, 1'b1, 1'b0, 1'b0, "01010010101");
        wait_idle8(1'b1);
        send8(8'hA5, 1'b1, 1'b1, 1'b0, "01010010111");
        wait_idle8(1'b0);
        send8(8'h07, 1'b1, 1'b1, 1'b1, "011100000011");
        wait_idle8(1'b1);
        send8(8'h00, 1'b1, 1'b1, 1'b1, "000000000111");
        wait_idle8(1'b0);
        send8(8'hFF, 1'b1, 1'b0, 1'b0, "01111111101");
        wait_idle8(1'b0);

        // Back-to-back: DATA_VALID held high across the first frame.
        @(negedge clk);
        p_data8 = 8'h55; par_en8 = 1'b0; par_typ8 = 1'b0; stop2_8 = 1'b0; dv8 = 1'b1;
        push8("0101010101");
        push8("0111100001");
        @(posedge clk);
        #1;
        p_data8 = 8'h0F;
        gaps = 0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (busy8 !== 1'b1) gaps++;
          if (i == 10) dv8 = 1'b0;
        end
        check("b2b_busy_gaps", gaps, 0);
        wait_idle8(1'b0);

        // Reset asserted during data bit 3, asynchronously to CLK.
        send8(8'hFF, 1'b0, 1'b0, 1'b0, "0111111111");
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_tx8", tx8, 1'b1);
        check("async_rst_busy8", busy8, 1'b0);
        q8.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        send8(8'h3C, 1'b1, 1'b0, 1'b0, "00011110001");
        wait_idle8(1'b0);

        // 5-bit payload instance.
        @(negedge clk);
        p_data5 = 5'h13; par_en5 = 1'b1; par_typ5 = 1'b0; stop2_5 = 1'b0; dv5 = 1'b1;
        push5("01100111");
        @(posedge clk);
        #1;
        dv5 = 1'b0;
        p_data5 = 5'h0C; par_en5 = 1'b0; par_typ5 = 1'b1; stop2_5 = 1'b1;
        wait_idle5();

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    join_any
  end

endmodule
